dmem_arbiter: RTL and testbench

Arbitrates the single-port data RAM between two requesters: port 0 is the CPU load/store path, and port 1 is a loader/debug master that writes programs and data or inspects memory. It issues at most one RAM access per cycle, using round-robin priority with an optional bus lock for port 1. It returns read data with the RAM's fixed 1-cycle latency and raises a stall to the CPU whenever its request is not accepted. It sits between the CPU datapath's memory signals (address, write data, MemWrite, DataType) and the RAM.

---
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data RAM: CPU (port 0) and loader/debug (port 1).
// Round-robin grants with a bounded bus lock for port 1 and 1-cycle read data routing.
module dmem_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_LOCK      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m0_req,
    input  logic                     m0_we,
    input  logic [1:0]               m0_type,
    input  logic [ADDRESS_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0]    m0_wdata,
    output logic                     m0_gnt,
    output logic                     m0_rvalid,
    output logic [DATA_WIDTH-1:0]    m0_rdata,
    output logic                     cpu_stall,
    input  logic                     m1_req,
    input  logic                     m1_we,
    input  logic [1:0]               m1_type,
    input  logic [ADDRESS_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0]    m1_wdata,
    input  logic                     m1_lock,
    output logic                     m1_gnt,
    output logic                     m1_rvalid,
    output logic [DATA_WIDTH-1:0]    m1_rdata,
    output logic                     ram_en,
    output logic                     ram_we,
    output logic [1:0]               ram_type,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    input  logic [DATA_WIDTH-1:0]    ram_rdata
);

    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        LOCKED = 2'd1,
        FORCE  = 2'd2
    } state_t;

    state_t        state;
    logic          prio;
    logic [CW-1:0] lock_cnt;
    logic          m0_rv_q;
    logic          m1_rv_q;
    logic          rr_g0;
    logic          rr_g1;
    logic          use_rr;

    always_comb begin
        rr_g0 = 1'b0;
        rr_g1 = 1'b0;
        if (m0_req && m1_req) begin
            rr_g0 = ~prio;
            rr_g1 = prio;
        end else begin
            rr_g0 = m0_req;
            rr_g1 = m1_req;
        end
    end

    // A LOCKED cycle whose lock has been dropped arbitrates exactly like ARB.
    assign use_rr = (state == ARB) || ((state == LOCKED) && !m1_lock);

    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (rst) begin
            if (use_rr) begin
                m0_gnt = rr_g0;
                m1_gnt = rr_g1;
            end else if (state == LOCKED) begin
                m1_gnt = m1_req;
            end else if (state == FORCE) begin
                m0_gnt = m0_req;
            end
        end
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_type  = 2'b00;
        ram_addr  = '0;
        ram_wdata = '0;
        if (m0_gnt) begin
            ram_we    = m0_we;
            ram_type  = m0_type;
            ram_addr  = m0_addr;
            ram_wdata = m0_wdata;
        end else if (m1_gnt) begin
            ram_we    = m1_we;
            ram_type  = m1_type;
            ram_addr  = m1_addr;
            ram_wdata = m1_wdata;
        end
    end

    assign ram_en    = m0_gnt | m1_gnt;
    assign cpu_stall = rst & m0_req & ~m0_gnt;

    // Gating with rst drops a response whose grant cycle was followed by reset.
    assign m0_rvalid = m0_rv_q & rst;
    assign m1_rvalid = m1_rv_q & rst;
    assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
    assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ARB;
            prio     <= 1'b0;
            lock_cnt <= '0;
            m0_rv_q  <= 1'b0;
            m1_rv_q  <= 1'b0;
        end else begin
            m0_rv_q <= m0_gnt & ~m0_we;
            m1_rv_q <= m1_gnt & ~m1_we;
            if (m0_gnt) begin
                prio <= 1'b1;
            end else if (m1_gnt) begin
                prio <= 1'b0;
            end
            case (state)
                ARB: begin
                    if (m1_gnt && m1_lock) begin
                        state    <= LOCKED;
                        lock_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (!m1_lock) begin
                        state <= ARB;
                    end else if (m0_req) begin
                        if (lock_cnt == LOCK_MAX) begin
                            state <= FORCE;
                        end else begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end
                    end
                end
                FORCE: begin
                    state <= ARB;
                    prio  <= 1'b1;
                end
                default: begin
                    state <= ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised + directed bench for dmem_arbiter: a flag-based arbitration model predicts
// grants and RAM commands; expected read responses go through a scoreboard queue.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int ML = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [1:0]    m0_type, m1_type;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, cpu_stall;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          ram_en, ram_we;
    logic [1:0]    ram_type;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_type(m0_type), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .cpu_stall(cpu_stall),
        .m1_req(m1_req), .m1_we(m1_we), .m1_type(m1_type), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_type(ram_type), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // RAM stub: one word per address (low 8 bits), read data one cycle after issue.
    bit [31:0] ram_mem [0:255];
    always @(posedge clk) begin
        if (ram_en && ram_we) ram_mem[ram_addr[7:0]] <= ram_wdata;
        if (ram_en && !ram_we) ram_rdata <= ram_mem[ram_addr[7:0]];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int          due;
        bit          port;
        logic [31:0] data;
    } resp_t;

    resp_t     sb[$];
    bit [31:0] ref_mem [0:255];

    // Reference model: who is favoured, whether port 1 holds the bus, how long port 0
    // has waited under that hold, and whether the next cycle is reserved for port 0.
    bit eg0, eg1;
    bit fav = 1'b0;
    bit hold = 1'b0;
    bit force_next = 1'b0;
    int waited = 0;

    always @(negedge clk) begin
        resp_t       item;
        logic        e_we;
        logic [1:0]  e_type;
        logic [31:0] e_addr, e_wdata;
        eg0 = 1'b0;
        eg1 = 1'b0;
        if (!rst) begin
            fav = 1'b0; hold = 1'b0; waited = 0; force_next = 1'b0;
        end else if (force_next) begin
            eg0 = m0_req;
            force_next = 1'b0;
            hold = 1'b0;
            fav = 1'b1;
        end else if (hold && m1_lock) begin
            eg1 = m1_req;
            if (m0_req) begin
                if (waited == ML) force_next = 1'b1;
                else waited++;
            end
            if (eg1) fav = 1'b0;
        end else begin
            hold = 1'b0;
            if (m0_req && m1_req) begin
                eg0 = !fav;
                eg1 = fav;
            end else begin
                eg0 = m0_req;
                eg1 = m1_req;
            end
            if (eg0) fav = 1'b1;
            if (eg1) fav = 1'b0;
            if (eg1 && m1_lock) begin
                hold = 1'b1;
                waited = 0;
            end
        end
        e_we = 1'b0; e_type = 2'b00; e_addr = '0; e_wdata = '0;
        if (eg0) begin
            e_we = m0_we; e_type = m0_type; e_addr = m0_addr; e_wdata = m0_wdata;
        end else if (eg1) begin
            e_we = m1_we; e_type = m1_type; e_addr = m1_addr; e_wdata = m1_wdata;
        end
        checkOutput("m0_gnt", {31'b0, m0_gnt}, {31'b0, eg0});
        checkOutput("m1_gnt", {31'b0, m1_gnt}, {31'b0, eg1});
        checkOutput("ram_en", {31'b0, ram_en}, {31'b0, eg0 | eg1});
        checkOutput("cpu_stall", {31'b0, cpu_stall}, {31'b0, rst & m0_req & !eg0});
        checkOutput("ram_we", {31'b0, ram_we}, {31'b0, e_we});
        checkOutput("ram_type", {30'b0, ram_type}, {30'b0, e_type});
        checkOutput("ram_addr", ram_addr, e_addr);
        checkOutput("ram_wdata", ram_wdata, e_wdata);
        if (eg0 | eg1) begin
            if (e_we) begin
                ref_mem[e_addr[7:0]] = e_wdata;
            end else begin
                item.due = cyc + 1;
                item.port = eg1;
                item.data = ref_mem[e_addr[7:0]];
                sb.push_back(item);
            end
        end
    end

    // Monitor: pops the response due this cycle and checks both read ports.
    always @(negedge clk) begin
        resp_t       item;
        bit          v0, v1;
        logic [31:0] d;
        #1;
        v0 = 1'b0; v1 = 1'b0; d = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            item = sb.pop_front();
            if (rst) begin
                d = item.data;
                if (item.port) v1 = 1'b1;
                else v0 = 1'b1;
            end
        end
        checkOutput("m0_rvalid", {31'b0, m0_rvalid}, {31'b0, v0});
        checkOutput("m1_rvalid", {31'b0, m1_rvalid}, {31'b0, v1});
        checkOutput("m0_rdata", m0_rdata, v0 ? d : 32'h0);
        checkOutput("m1_rdata", m1_rdata, v1 ? d : 32'h0);
    end

    task automatic applyStimulus(
        input bit r,
        input bit q0, input bit w0, input logic [1:0] t0, input logic [31:0] a0, input logic [31:0] d0,
        input bit q1, input bit w1, input logic [1:0] t1, input logic [31:0] a1, input logic [31:0] d1,
        input bit lk, input int n);
        rst = r;
        m0_req = q0; m0_we = w0; m0_type = t0; m0_addr = a0; m0_wdata = d0;
        m1_req = q1; m1_we = w1; m1_type = t1; m1_addr = a1; m1_wdata = d1;
        m1_lock = lk;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    bit          p0, p1, pw0, pw1, lk;
    logic [1:0]  pt0, pt1;
    logic [31:0] pa0, pa1, pd0, pd1;

    initial begin
        $display("[TB] reset with both ports requesting");
        applyStimulus(0, 1,0,2'd2,32'h10,0, 1,0,2'd2,32'h20,0, 0, 2);
        applyStimulus(1, 0,1,2'd2,32'h40,32'hDEADBEEF, 0,0,2'd0,0,0, 0, 0);
        $display("[TB] single requester writes then reads back");
        applyStimulus(1, 1,1,2'd2,32'h40,32'hDEADBEEF, 0,0,2'd0,0,0, 0, 3);
        applyStimulus(1, 1,0,2'd2,32'h40,0, 0,0,2'd0,0,0, 0, 1);
        applyStimulus(1, 0,0,2'd0,0,0, 1,1,2'd2,32'h10,32'h1111_0010, 0, 1);
        applyStimulus(1, 0,0,2'd0,0,0, 1,1,2'd1,32'h20,32'h2222_0020, 0, 1);
        $display("[TB] contention between continuous reads");
        applyStimulus(1, 1,0,2'd2,32'h10,0, 1,0,2'd2,32'h20,0, 0, 8);
        $display("[TB] lock held until forced release");
        applyStimulus(1, 0,0,2'd0,0,0, 1,0,2'd2,32'h20,0, 1, 1);
        applyStimulus(1, 1,0,2'd2,32'h10,0, 1,0,2'd2,32'h20,0, 1, 9);
        $display("[TB] lock dropped early");
        applyStimulus(1, 0,0,2'd0,0,0, 0,0,2'd0,0,0, 0, 1);
        applyStimulus(1, 0,0,2'd0,0,0, 1,0,2'd2,32'h20,0, 1, 1);
        applyStimulus(1, 1,0,2'd2,32'h40,0, 1,0,2'd2,32'h20,0, 1, 2);
        applyStimulus(1, 1,0,2'd2,32'h40,0, 1,0,2'd2,32'h20,0, 0, 2);
        $display("[TB] reset while a read is outstanding");
        applyStimulus(1, 0,0,2'd0,0,0, 1,0,2'd2,32'h40,0, 1, 1);
        applyStimulus(0, 0,0,2'd0,0,0, 1,0,2'd2,32'h40,0, 1, 1);
        applyStimulus(1, 1,0,2'd2,32'h10,0, 1,0,2'd2,32'h20,0, 0, 2);
        applyStimulus(1, 0,0,2'd0,0,0, 0,0,2'd0,0,0, 0, 1);

        $display("[TB] randomised traffic");
        p0 = 0; p1 = 0; lk = 0;
        pw0 = 0; pw1 = 0; pt0 = 0; pt1 = 0; pa0 = 0; pa1 = 0; pd0 = 0; pd1 = 0;
        for (int i = 0; i < 800; i++) begin
            if (p0 && eg0) p0 = 0;
            if (p1 && eg1) p1 = 0;
            if (!p0 && ($urandom % 3) != 0) begin
                p0 = 1; pw0 = $urandom % 2; pt0 = 2'($urandom_range(0, 2));
                pa0 = $urandom_range(0, 63); pd0 = $urandom;
            end
            if (!p1 && ($urandom % 3) != 0) begin
                p1 = 1; pw1 = $urandom % 2; pt1 = 2'($urandom_range(0, 2));
                pa1 = $urandom_range(0, 63); pd1 = $urandom;
            end
            if (($urandom % 8) == 0) lk = !lk;
            applyStimulus(($urandom % 64) != 0, p0,pw0,pt0,pa0,pd0, p1,pw1,pt1,pa1,pd1, lk, 1);
        end
        applyStimulus(1, 0,0,2'd0,0,0, 0,0,2'd0,0,0, 0, 3);
        checkOutput("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
